dct_block_scheduler: RTL and testbench
======================================

// Module: dct_block_scheduler
// PURPOSE
//  Shares one 4x4 DCT engine between two block sources. Grants one source at a time
//  (round-robin) and streams its 16 signed 8-bit samples, row-major, into the engine.
//  Collects the engine's 16 signed 10-bit coefficients, tags them with the source id,
//  and aborts with an error pulse if the engine stalls or breaks its output burst.
// PARAMETERS
//  TIMEOUT  64  max cycles in WAIT (after last fed sample) before core_out_valid; >=2
//  BLK_LEN  16  samples per block (fixed at 16; parameter exists only for the package)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous reset, active-low
//  src_req        in   2   src_req[i]=1: source i holds a complete block ready
//  src_gnt        out  2   one-hot grant; high exactly 16 consecutive cycles per block
//  src0_data      in   8   signed sample from source 0, valid while src_gnt[0]
//  src1_data      in   8   signed sample from source 1, valid while src_gnt[1]
//  core_in_valid  out  1   to engine: sample strobe
//  core_in_data   out  8   to engine: signed sample
//  core_out_valid in   1   from engine: coefficient strobe, 16-cycle burst
//  core_out_data  in   10  from engine: signed coefficient
//  res_valid      out  1   tagged result strobe
//  res_data       out  10  signed coefficient, row-major order
//  res_id         out  1   source id of current result or error
//  err            out  1   one-cycle pulse: block aborted (timeout or broken burst)
//  busy           out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, cnt 0, rr pointer last=1 (src0 wins first).
//  - All outputs registered. States: IDLE, FEED, WAIT, DRAIN.
//  - IDLE: if src_req!=0, pick winner (round-robin: prefer !last when both set,
//    else the only requester) -> FEED. src_gnt[winner] rises next cycle; cnt=0.
//  - FEED: src_gnt held 16 cycles (cnt 0..15). The sample presented in gnt cycle k
//    appears on core_in_data with core_in_valid one cycle later (latency 1).
//    At cnt==15 -> WAIT; src_gnt drops; core_in_valid drops one cycle later.
//    src_req changes during FEED are ignored; the source owes all 16 samples.
//  - WAIT: timeout counter starts at 0. core_out_valid=1 -> DRAIN, and that first
//    coefficient is captured. Counter reaches TIMEOUT-1 with no core_out_valid ->
//    err=1 for one cycle with res_id=winner -> IDLE; last=winner.
//  - DRAIN: each core_out_valid cycle -> res_valid=1, res_data=core_out_data,
//    res_id=winner, all one cycle later (latency 1). After the 16th coefficient ->
//    IDLE, last=winner. If core_out_valid drops before 16 coefficients: no more
//    res_valid, err pulse, -> IDLE, last=winner.
//  - core_out_valid in IDLE/FEED is ignored (no res_valid, no err).
//  - Block spacing: IDLE lasts >=1 cycle, so core_in_valid is low >=2 cycles between
//    blocks. This satisfies the engine's idle-gap requirement.
//  - No arithmetic on data; widths pass through unchanged (sign preserved).
//  - Reset mid-block: immediate abort. Grant and strobes drop asynchronously; no err.
// STRUCTURE
//  - dct_sched_pkg: state_t enum {IDLE,FEED,WAIT,DRAIN}, BLK_LEN=16, SAMP_W=8,
//    COEF_W=10, CNT_W=$clog2(BLK_LEN).
//  - Sub-module rr_arb2: 2-req round-robin arbiter. Inputs: req[1:0], last,
//    update/en. Outputs: winner id, any.
//  - Top holds the FSM, 4-bit block counter, timeout counter
//    ($clog2(TIMEOUT) bits), and output registers.
// TESTING
//  1 Single src0 block, samples -8..7, engine model latency 3 -> src_gnt=01 for 16
//    cycles; core_in_data mirrors the samples 1 cycle later; res_id=0;
//    16 res_valid cycles; busy drops after.
//  2 src_req=11 held for 4 blocks -> grant order 0,1,0,1; res_id follows the same order.
//  3 Engine never responds, TIMEOUT=64 -> err pulses 64 cycles after WAIT entry,
//    res_valid never rises, next request is granted normally.
//  4 Engine burst drops after 9 coefficients -> exactly 9 res_valid, then err=1
//    for one cycle, state IDLE.
//  5 rst_n low at FEED cnt=7 -> src_gnt, core_in_valid and busy all 0 at once;
//    after release src0 is granted first.
//  6 Stray core_out_valid in IDLE, and src_req dropped mid-FEED -> no res_valid and
//    no err from the stray strobe; grant still lasts 16 cycles.

Source files
------------

// File: rtl/dct_sched_pkg.sv
// Shared types and constants for the DCT block scheduler.
//   state_t : scheduler FSM states
//   res_t   : registered result bundle (strobe, source tag, coefficient)
package dct_sched_pkg;

    localparam int BLK_LEN = 16;
    localparam int SAMP_W  = 8;
    localparam int COEF_W  = 10;
    localparam int CNT_W   = $clog2(BLK_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              id;
        logic [COEF_W-1:0] data;
    } res_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (combinational).
//   req[1:0] : request lines
//   last     : id granted most recently
//   en       : arbitration enabled (scheduler idle)
//   winner   : chosen id; the requester other than 'last' wins a tie
//   any      : en and at least one request pending
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic       winner,
    output logic       any
);

    assign any    = en & (|req);
    // With a single requester req[1] alone names it; on a tie rotate away from last.
    assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dct_block_scheduler.sv
// Shares one 4x4 DCT engine between two block sources.
//   clk, rst_n            : clock, async active-low reset
//   src_req[1:0]          : source i has a full block ready
//   src_gnt[1:0]          : one-hot grant, 16 cycles per block
//   src0_data, src1_data  : signed samples from each source
//   core_in_valid/data    : sample stream to the engine (1-cycle latency)
//   core_out_valid/data   : coefficient burst from the engine
//   res_valid/data/id     : tagged coefficients (1-cycle latency)
//   err                   : one-cycle abort pulse (timeout or broken burst)
//   busy                  : scheduler not in IDLE
module dct_block_scheduler
    import dct_sched_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        src_req,
    output logic [1:0]        src_gnt,
    input  logic [SAMP_W-1:0] src0_data,
    input  logic [SAMP_W-1:0] src1_data,
    output logic              core_in_valid,
    output logic [SAMP_W-1:0] core_in_data,
    input  logic              core_out_valid,
    input  logic [COEF_W-1:0] core_out_data,
    output logic              res_valid,
    output logic [COEF_W-1:0] res_data,
    output logic              res_id,
    output logic              err,
    output logic              busy
);

    localparam int TO_W = $clog2(TIMEOUT);

    state_t            state;
    logic [CNT_W-1:0]  cnt;      // samples fed in FEED, coefficients taken in DRAIN
    logic [TO_W-1:0]   tcnt;
    logic              last;
    logic              win_id;
    logic              arb_win;
    logic              arb_any;
    logic [SAMP_W-1:0] samp;
    res_t              res_r;

    rr_arb2 u_arb (
        .req    (src_req),
        .last   (last),
        .en     (state == IDLE),
        .winner (arb_win),
        .any    (arb_any)
    );

    assign samp      = win_id ? src1_data : src0_data;
    assign res_valid = res_r.valid;
    assign res_id    = res_r.id;
    assign res_data  = res_r.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            tcnt          <= '0;
            last          <= 1'b1;
            win_id        <= 1'b0;
            src_gnt       <= 2'b00;
            core_in_valid <= 1'b0;
            core_in_data  <= '0;
            res_r         <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            core_in_valid <= 1'b0;
            res_r.valid   <= 1'b0;
            err           <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state   <= FEED;
                        win_id  <= arb_win;
                        src_gnt <= arb_win ? 2'b10 : 2'b01;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                FEED: begin
                    // Requests are not looked at here: the granted source owes the full block.
                    core_in_valid <= 1'b1;
                    core_in_data  <= samp;
                    if (cnt == CNT_W'(BLK_LEN - 1)) begin
                        state   <= WAIT;
                        src_gnt <= 2'b00;
                        tcnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (core_out_valid) begin
                        state <= DRAIN;
                        res_r <= '{valid: 1'b1, id: win_id, data: core_out_data};
                        cnt   <= CNT_W'(1);
                    end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        res_r.id <= win_id;
                        last     <= win_id;
                        busy     <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (core_out_valid) begin
                        res_r <= '{valid: 1'b1, id: win_id, data: core_out_data};
                        if (cnt == CNT_W'(BLK_LEN - 1)) begin
                            state <= IDLE;
                            last  <= win_id;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Burst ended early: drop the rest of the block.
                        state    <= IDLE;
                        err      <= 1'b1;
                        res_r.id <= win_id;
                        last     <= win_id;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_scheduler.sv
module tb_dct_block_scheduler;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] src_req = 2'b00;
    logic [1:0] src_gnt;
    logic [7:0] src0_data = 8'd0;
    logic [7:0] src1_data = 8'd0;
    logic       core_in_valid;
    logic [7:0] core_in_data;
    logic       core_out_valid;
    logic [9:0] core_out_data;
    logic       res_valid;
    logic [9:0] res_data;
    logic       res_id;
    logic       err;
    logic       busy;

    dct_block_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_gnt(src_gnt),
        .src0_data(src0_data), .src1_data(src1_data),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit m_last = 1'b1;        // model of the round-robin pointer
    int samp_mode = 0;        // 0: samples k-8, 1: random
    int eng_lat = 3;
    int eng_n = 16;           // coefficients the engine model emits per block
    logic stray_v = 1'b0;

    int cyc = 0;
    bit [31:0] rnd = 32'd0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd <= $urandom;

    // Observation logs (written only by the monitor / engine processes)
    int         gnt_id_q[$], gnt_len_q[$], gnt_start_q[$], gnt_end_q[$];
    logic [8:0] src_q[$];
    logic [7:0] in_q[$];
    int         in_cyc_q[$];
    logic [10:0] res_q[$];
    int         res_cyc_q[$];
    int         err_cyc_q[$];
    logic       err_id_q[$];
    logic [9:0] coef_q[$];
    int         coef_cyc_q[$];
    int         g_run = 0;

    function automatic logic [7:0] samp_val(int k, bit [31:0] r);
        return (samp_mode == 0) ? 8'(k - 8) : r[7:0];
    endfunction

    // Sources and monitor
    always @(negedge clk) begin
        if (src_gnt != 2'b00 && g_run == 0) begin
            gnt_id_q.push_back(int'(src_gnt[1]));
            gnt_start_q.push_back(cyc);
        end
        if (src_gnt == 2'b00 && g_run != 0) begin
            gnt_len_q.push_back(g_run);
            gnt_end_q.push_back(cyc - 1);
        end
        g_run <= (src_gnt != 2'b00) ? g_run + 1 : 0;
        if (src_gnt[0]) begin
            src0_data <= samp_val(g_run, rnd);
            src_q.push_back({1'b0, samp_val(g_run, rnd)});
        end else src0_data <= rnd[15:8];
        if (src_gnt[1]) begin
            src1_data <= samp_val(g_run, rnd);
            src_q.push_back({1'b1, samp_val(g_run, rnd)});
        end else src1_data <= rnd[31:24];
        if (core_in_valid) begin in_q.push_back(core_in_data); in_cyc_q.push_back(cyc); end
        if (res_valid) begin res_q.push_back({res_id, res_data}); res_cyc_q.push_back(cyc); end
        if (err) begin err_cyc_q.push_back(cyc); err_id_q.push_back(res_id); end
    end

    // Engine model: after 16 samples, wait eng_lat cycles, emit eng_n coefficients
    int e_in = 0, e_dly = -1, e_left = 0;
    logic eng_v = 1'b0;
    logic [9:0] eng_d = 10'd0;
    assign core_out_valid = eng_v | stray_v;
    assign core_out_data  = eng_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_in <= 0; e_dly <= -1; e_left <= 0; eng_v <= 1'b0;
        end else begin
            eng_v <= 1'b0;
            if (core_in_valid) begin
                if (e_in == 15) begin e_in <= 0; e_dly <= eng_lat; end
                else e_in <= e_in + 1;
            end
            if (e_dly > 0) e_dly <= e_dly - 1;
            else if (e_dly == 0) begin e_dly <= -1; e_left <= eng_n; end
            if (e_left > 0) begin
                eng_v <= 1'b1;
                eng_d <= rnd[25:16];
                coef_q.push_back(rnd[25:16]);
                coef_cyc_q.push_back(cyc);
                e_left <= e_left - 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (src_gnt != 2'b00) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src_req = 2'b00; stray_v = 1'b0;
        repeat (3) tick();
        total++; if (src_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", src_gnt); end
        total++; if (core_in_valid !== 1'b0) begin bad++; $display("FAIL reset_civ: got %b want 0", core_in_valid); end
        total++; if (core_in_data !== 8'd0) begin bad++; $display("FAIL reset_cid: got %h want 00", core_in_data); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", res_valid); end
        total++; if (res_data !== 10'd0 || res_id !== 1'b0) begin bad++; $display("FAIL reset_res: got %h/%b want 0/0", res_data, res_id); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1; m_last = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int g0, i0, r0, c0, e0; bit ok;
        samp_mode = 0; eng_lat = 3; eng_n = 16;
        g0 = gnt_id_q.size(); i0 = in_q.size(); r0 = res_q.size(); c0 = coef_q.size(); e0 = err_cyc_q.size();
        src_req = 2'b01;
        wait_gnt(10, ok); src_req = 2'b00;
        total++; if (!ok) begin bad++; $display("FAIL single_gnt_wait: got none want grant"); end
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_idle_wait: got busy want idle"); end
        total++; if (gnt_id_q.size() != g0 + 1 || gnt_id_q[g0] != 0 || gnt_len_q[g0] != 16) begin
            bad++; $display("FAIL single_gnt: got id %0d len %0d want id 0 len 16", gnt_id_q[g0], gnt_len_q[g0]); end
        total++; if (in_q.size() != i0 + 16) begin bad++; $display("FAIL single_in_cnt: got %0d want 16", in_q.size() - i0); end
        for (int k = 0; k < 16; k++) begin
            total++; if (in_q[i0 + k] !== 8'(k - 8)) begin bad++; $display("FAIL single_in[%0d]: got %h want %h", k, in_q[i0 + k], 8'(k - 8)); end
        end
        total++; if (in_cyc_q[i0] - gnt_start_q[g0] != 1) begin bad++; $display("FAIL single_in_lat: got %0d want 1", in_cyc_q[i0] - gnt_start_q[g0]); end
        total++; if (res_q.size() != r0 + 16) begin bad++; $display("FAIL single_res_cnt: got %0d want 16", res_q.size() - r0); end
        for (int k = 0; k < 16; k++) begin
            total++; if (res_q[r0 + k] !== {1'b0, coef_q[c0 + k]}) begin bad++; $display("FAIL single_res[%0d]: got %h want %h", k, res_q[r0 + k], {1'b0, coef_q[c0 + k]}); end
        end
        total++; if (res_cyc_q[r0] - coef_cyc_q[c0] != 1) begin bad++; $display("FAIL single_res_lat: got %0d want 1", res_cyc_q[r0] - coef_cyc_q[c0]); end
        total++; if (err_cyc_q.size() != e0) begin bad++; $display("FAIL single_err: got %0d want 0", err_cyc_q.size() - e0); end
        m_last = 1'b0;
    endtask

    task automatic test_rr();
        int g0, i0, r0, c0, s0, e0; bit ok; logic exp_id [4];
        samp_mode = 1; eng_lat = $urandom_range(0, 4); eng_n = 16;
        g0 = gnt_id_q.size(); i0 = in_q.size(); r0 = res_q.size(); c0 = coef_q.size(); s0 = src_q.size(); e0 = err_cyc_q.size();
        for (int b = 0; b < 4; b++) begin exp_id[b] = ~m_last; m_last = exp_id[b]; end
        src_req = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (gnt_id_q.size() >= g0 + 4) begin ok = 1'b1; break; end
            tick();
        end
        src_req = 2'b00;
        total++; if (!ok) begin bad++; $display("FAIL rr_gnt_wait: got %0d grants want 4", gnt_id_q.size() - g0); end
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_idle_wait: got busy want idle"); end
        for (int b = 0; b < 4; b++) begin
            total++; if (gnt_id_q[g0 + b] != int'(exp_id[b]) || gnt_len_q[g0 + b] != 16) begin
                bad++; $display("FAIL rr_gnt[%0d]: got id %0d len %0d want id %0d len 16", b, gnt_id_q[g0 + b], gnt_len_q[g0 + b], exp_id[b]); end
        end
        total++; if (in_q.size() != i0 + 64 || res_q.size() != r0 + 64) begin
            bad++; $display("FAIL rr_counts: got in %0d res %0d want 64 64", in_q.size() - i0, res_q.size() - r0); end
        for (int k = 0; k < 64; k++) begin
            total++; if (in_q[i0 + k] !== src_q[s0 + k][7:0] || src_q[s0 + k][8] !== exp_id[k / 16]) begin
                bad++; $display("FAIL rr_in[%0d]: got %h want %h", k, in_q[i0 + k], src_q[s0 + k]); end
            total++; if (res_q[r0 + k] !== {exp_id[k / 16], coef_q[c0 + k]}) begin
                bad++; $display("FAIL rr_res[%0d]: got %h want %h", k, res_q[r0 + k], {exp_id[k / 16], coef_q[c0 + k]}); end
        end
        for (int b = 1; b < 4; b++) begin
            total++; if (in_cyc_q[i0 + 16 * b] - in_cyc_q[i0 + 16 * b - 1] < 3) begin
                bad++; $display("FAIL rr_gap[%0d]: got %0d want >=3", b, in_cyc_q[i0 + 16 * b] - in_cyc_q[i0 + 16 * b - 1]); end
        end
        total++; if (err_cyc_q.size() != e0) begin bad++; $display("FAIL rr_err: got %0d want 0", err_cyc_q.size() - e0); end
    endtask

    task automatic test_timeout();
        int g0, r0, c0, e0; bit ok; logic id; logic w;
        eng_n = 0; eng_lat = 2;
        id = 1'($urandom_range(0, 1));
        g0 = gnt_id_q.size(); r0 = res_q.size(); e0 = err_cyc_q.size();
        src_req = id ? 2'b10 : 2'b01;
        wait_gnt(10, ok); src_req = 2'b00;
        wait_idle(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_idle_wait: got busy want idle"); end
        total++; if (err_cyc_q.size() != e0 + 1) begin bad++; $display("FAIL to_err_cnt: got %0d want 1", err_cyc_q.size() - e0); end
        total++; if (err_cyc_q[e0] != gnt_end_q[g0] + 1 + TIMEOUT) begin
            bad++; $display("FAIL to_err_time: got %0d want %0d", err_cyc_q[e0] - gnt_end_q[g0] - 1, TIMEOUT); end
        total++; if (err_id_q[e0] !== id) begin bad++; $display("FAIL to_err_id: got %b want %b", err_id_q[e0], id); end
        total++; if (res_q.size() != r0) begin bad++; $display("FAIL to_res: got %0d want 0", res_q.size() - r0); end
        m_last = id;
        // Recovery block with both sources requesting
        eng_n = 16; w = ~m_last;
        g0 = gnt_id_q.size(); r0 = res_q.size(); c0 = coef_q.size(); e0 = err_cyc_q.size();
        src_req = 2'b11;
        wait_gnt(10, ok); src_req = 2'b00;
        wait_idle(200, ok);
        total++; if (!ok || gnt_id_q[g0] != int'(w) || gnt_len_q[g0] != 16) begin
            bad++; $display("FAIL to_next_gnt: got id %0d len %0d want id %0d len 16", gnt_id_q[g0], gnt_len_q[g0], w); end
        total++; if (res_q.size() != r0 + 16 || res_q[r0 + 15] !== {w, coef_q[c0 + 15]} || err_cyc_q.size() != e0) begin
            bad++; $display("FAIL to_next_res: got %0d results want 16 tagged %b", res_q.size() - r0, w); end
        m_last = w;
    endtask

    task automatic test_burst_break();
        int r0, c0, e0; bit ok; logic w;
        eng_n = 9; eng_lat = $urandom_range(0, 4); w = ~m_last;
        r0 = res_q.size(); c0 = coef_q.size(); e0 = err_cyc_q.size();
        src_req = 2'b11;
        wait_gnt(10, ok); src_req = 2'b00;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL brk_idle_wait: got busy want idle"); end
        total++; if (res_q.size() != r0 + 9) begin bad++; $display("FAIL brk_res_cnt: got %0d want 9", res_q.size() - r0); end
        for (int k = 0; k < 9; k++) begin
            total++; if (res_q[r0 + k] !== {w, coef_q[c0 + k]}) begin bad++; $display("FAIL brk_res[%0d]: got %h want %h", k, res_q[r0 + k], {w, coef_q[c0 + k]}); end
        end
        total++; if (err_cyc_q.size() != e0 + 1) begin bad++; $display("FAIL brk_err_cnt: got %0d want 1", err_cyc_q.size() - e0); end
        total++; if (err_cyc_q[e0] != res_cyc_q[r0 + 8] + 1 || err_id_q[e0] !== w) begin
            bad++; $display("FAIL brk_err: got cyc+%0d id %b want cyc+1 id %b", err_cyc_q[e0] - res_cyc_q[r0 + 8], err_id_q[e0], w); end
        tick();
        total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL brk_after: got err %b busy %b want 0 0", err, busy); end
        m_last = w; eng_n = 16;
    endtask

    task automatic test_reset_midblock();
        int g0, r0, c0, e0; bit ok;
        eng_lat = 3; eng_n = 16;
        e0 = err_cyc_q.size();
        src_req = 2'b11;
        wait_gnt(10, ok); src_req = 2'b00;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        total++; if (src_gnt !== 2'b00) begin bad++; $display("FAIL mid_rst_gnt: got %b want 00", src_gnt); end
        total++; if (core_in_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_civ: got %b want 0", core_in_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        repeat (3) tick();
        total++; if (err_cyc_q.size() != e0) begin bad++; $display("FAIL mid_rst_err: got %0d want 0", err_cyc_q.size() - e0); end
        g0 = gnt_id_q.size(); r0 = res_q.size(); c0 = coef_q.size();
        rst_n = 1'b1; m_last = 1'b1;
        src_req = 2'b11;
        wait_gnt(10, ok); src_req = 2'b00;
        total++; if (!ok || src_gnt !== 2'b01) begin bad++; $display("FAIL mid_first_gnt: got %b want 01", src_gnt); end
        wait_idle(200, ok);
        total++; if (!ok || res_q.size() != r0 + 16 || res_q[r0] !== {1'b0, coef_q[c0]} || gnt_len_q[g0] != 16) begin
            bad++; $display("FAIL mid_block: got %0d results want 16 tagged 0", res_q.size() - r0); end
        m_last = 1'b0;
    endtask

    task automatic test_stray();
        int g0, i0, r0, c0, s0, e0; bit ok;
        samp_mode = 1; eng_lat = 1; eng_n = 16;
        r0 = res_q.size(); e0 = err_cyc_q.size();
        stray_v = 1'b1; tick(); stray_v = 1'b0;
        repeat (3) tick();
        total++; if (res_q.size() != r0 || err_cyc_q.size() != e0 || busy !== 1'b0) begin
            bad++; $display("FAIL stray_idle: got res %0d err %0d busy %b want 0 0 0", res_q.size() - r0, err_cyc_q.size() - e0, busy); end
        g0 = gnt_id_q.size(); i0 = in_q.size(); c0 = coef_q.size(); s0 = src_q.size();
        src_req = 2'b10;
        wait_gnt(10, ok);
        repeat (5) tick();
        src_req = 2'b00;
        stray_v = 1'b1; tick(); stray_v = 1'b0;
        wait_idle(200, ok);
        total++; if (!ok || gnt_id_q[g0] != 1 || gnt_len_q[g0] != 16) begin
            bad++; $display("FAIL stray_gnt: got id %0d len %0d want id 1 len 16", gnt_id_q[g0], gnt_len_q[g0]); end
        total++; if (in_q.size() != i0 + 16 || in_q[i0 + 15] !== src_q[s0 + 15][7:0]) begin
            bad++; $display("FAIL stray_in: got %0d samples want 16", in_q.size() - i0); end
        total++; if (res_q.size() != r0 + 16 || res_q[r0] !== {1'b1, coef_q[c0]} || res_q[r0 + 15] !== {1'b1, coef_q[c0 + 15]}) begin
            bad++; $display("FAIL stray_res: got %0d results want 16 tagged 1", res_q.size() - r0); end
        total++; if (err_cyc_q.size() != e0) begin bad++; $display("FAIL stray_err: got %0d want 0", err_cyc_q.size() - e0); end
        m_last = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_timeout();
        test_burst_break();
        test_reset_midblock();
        test_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
